// File: rtl/argmax_classifier.sv
// Sequential argmax over the FC2 class scores: reports winning digit, its raw
// score, best-minus-runner-up margin on the ordering key, and captured overflow.
module argmax_classifier #(
    parameter int unsigned N_CLASSES = 10,
    parameter int unsigned SCORE_W   = 8
) (
    input  logic                           clk,
    input  logic                           iRst,
    input  logic                           ena,
    input  logic                           start,
    input  logic [N_CLASSES*SCORE_W-1:0]   iScores,
    input  logic                           iOverflow,
    output logic                           busy,
    output logic                           done,
    output logic [3:0]                     digit,
    output logic [SCORE_W-1:0]             maxScore,
    output logic [SCORE_W-1:0]             margin,
    output logic                           overflow
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned VEC_W = N_CLASSES * SCORE_W;
    localparam int unsigned MAG_W = SCORE_W - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_e;

    state_e               state_q,      state_d;
    logic [VEC_W-1:0]     latch_q,      latch_d;
    logic                 ovf_lat_q,    ovf_lat_d;
    logic [IDX_W-1:0]     idx_q,        idx_d;
    logic [SCORE_W-1:0]   best_key_q,   best_key_d;
    logic [IDX_W-1:0]     best_idx_q,   best_idx_d;
    logic [SCORE_W-1:0]   best_raw_q,   best_raw_d;
    logic [SCORE_W-1:0]   second_key_q, second_key_d;
    logic                 busy_q,       busy_d;
    logic                 done_q,       done_d;
    logic [3:0]           digit_q,      digit_d;
    logic [SCORE_W-1:0]   max_q,        max_d;
    logic [SCORE_W-1:0]   margin_q,     margin_d;
    logic                 overflow_q,   overflow_d;

    logic [SCORE_W-1:0]   cur_raw_c;
    logic [SCORE_W-1:0]   cur_key_c;

    // Sign-magnitude to monotonic unsigned key; negative zero folds onto +0.
    function automatic logic [SCORE_W-1:0] score_key(input logic [SCORE_W-1:0] s);
        if (!s[SCORE_W-1])
            return {1'b1, s[MAG_W-1:0]};
        else if (s[MAG_W-1:0] == '0)
            return {1'b1, MAG_W'(0)};
        else
            return {1'b0, ~s[MAG_W-1:0]};
    endfunction

    // The latch shifts down one score per scan cycle, so the current score is always the low byte.
    assign cur_raw_c = latch_q[SCORE_W-1:0];
    assign cur_key_c = score_key(cur_raw_c);

    always_comb begin
        state_d      = state_q;
        latch_d      = latch_q;
        ovf_lat_d    = ovf_lat_q;
        idx_d        = idx_q;
        best_key_d   = best_key_q;
        best_idx_d   = best_idx_q;
        best_raw_d   = best_raw_q;
        second_key_d = second_key_q;
        busy_d       = busy_q;
        done_d       = done_q;
        digit_d      = digit_q;
        max_d        = max_q;
        margin_d     = margin_q;
        overflow_d   = overflow_q;

        if (ena) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        latch_d   = iScores;
                        ovf_lat_d = iOverflow;
                        idx_d     = '0;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        state_d   = S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (idx_q == '0) begin
                        best_key_d   = cur_key_c;
                        best_idx_d   = '0;
                        best_raw_d   = cur_raw_c;
                        second_key_d = '0;
                    end else if (cur_key_c > best_key_q) begin
                        second_key_d = best_key_q;
                        best_key_d   = cur_key_c;
                        best_idx_d   = idx_q;
                        best_raw_d   = cur_raw_c;
                    end else if (cur_key_c >= second_key_q) begin
                        second_key_d = cur_key_c;
                    end

                    latch_d = latch_q >> SCORE_W;
                    idx_d   = idx_q + IDX_W'(1);

                    // Last score is folded into the published result on the same edge.
                    if (idx_q == IDX_W'(N_CLASSES - 1)) begin
                        digit_d    = best_idx_d;
                        max_d      = best_raw_d;
                        margin_d   = best_key_d - second_key_d;
                        overflow_d = ovf_lat_q;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state_q      <= S_IDLE;
            latch_q      <= '0;
            ovf_lat_q    <= 1'b0;
            idx_q        <= '0;
            best_key_q   <= '0;
            best_idx_q   <= '0;
            best_raw_q   <= '0;
            second_key_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            digit_q      <= '0;
            max_q        <= '0;
            margin_q     <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            latch_q      <= latch_d;
            ovf_lat_q    <= ovf_lat_d;
            idx_q        <= idx_d;
            best_key_q   <= best_key_d;
            best_idx_q   <= best_idx_d;
            best_raw_q   <= best_raw_d;
            second_key_q <= second_key_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            digit_q      <= digit_d;
            max_q        <= max_d;
            margin_q     <= margin_d;
            overflow_q   <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign digit    = digit_q;
    assign maxScore = max_q;
    assign margin   = margin_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: expected results are queued at each
// accepted start and compared when done rises.
module tb_argmax_classifier;

    typedef logic [9:0][7:0] vec_t;

    logic        clk = 1'b0;
    logic        iRst;
    logic        ena;
    logic        start;
    vec_t        iScores;
    logic        iOverflow;
    logic        busy;
    logic        done;
    logic [3:0]  digit;
    logic [7:0]  maxScore;
    logic [7:0]  margin;
    logic        overflow;

    int          checks = 0;
    int          errors = 0;
    logic [20:0] exp_q[$];

    argmax_classifier dut (
        .clk       (clk),
        .iRst      (iRst),
        .ena       (ena),
        .start     (start),
        .iScores   (iScores),
        .iOverflow (iOverflow),
        .busy      (busy),
        .done      (done),
        .digit     (digit),
        .maxScore  (maxScore),
        .margin    (margin),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference: key is the score's rank on the signed number line, with -0 equal to +0.
    function automatic logic [20:0] model(input vec_t s, input logic ov);
        int k[10];
        int bi;
        int sec;
        for (int i = 0; i < 10; i++) begin
            int mag;
            mag = int'(s[i][6:0]);
            if (!s[i][7])     k[i] = 128 + mag;
            else if (mag == 0) k[i] = 128;
            else               k[i] = 127 - mag;
        end
        bi = 0;
        for (int i = 1; i < 10; i++) if (k[i] > k[bi]) bi = i;
        sec = 0;
        for (int i = 0; i < 10; i++) if (i != bi && k[i] > sec) sec = k[i];
        return {4'(bi), s[bi], 8'(k[bi] - sec), ov};
    endfunction

    task automatic start_scan(input vec_t s, input logic ov);
        iScores   = s;
        iOverflow = ov;
        start     = 1'b1;
        exp_q.push_back(model(s, ov));
        @(posedge clk); #1;
        start     = 1'b0;
        iScores   = {$urandom, $urandom, $urandom};
        iOverflow = ~ov;
    endtask

    task automatic wait_done(inout int cyc);
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        iRst = 1'b1; ena = 1'b1; start = 1'b0; iScores = '1; iOverflow = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, digit, maxScore, margin, overflow} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {busy, done, digit, maxScore, margin, overflow});
        end
        iRst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_and_check(input string name, input vec_t s, input logic ov);
        int cyc = 0;
        logic [20:0] exp;
        start_scan(s, ov);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after_start got busy=%b done=%b exp busy=1 done=0", name, busy, done);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 10 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_latency got %0d busy=%b exp 10 busy=0", name, cyc, busy);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({digit, maxScore, margin, overflow} !== exp) begin
            errors++;
            $display("FAIL %s_result got %h exp %h", name, {digit, maxScore, margin, overflow}, exp);
        end
    endtask

    task automatic test_distinct();
        vec_t s;
        s[0] = 8'h10; s[1] = 8'h05; s[2] = 8'h30; s[3] = 8'h00; s[4] = 8'h2F;
        s[5] = 8'h12; s[6] = 8'h20; s[7] = 8'h5A; s[8] = 8'h01; s[9] = 8'h1F;
        run_and_check("distinct", s, 1'b0);
        checks++;
        if (digit !== 4'd7 || maxScore !== 8'h5A || margin !== 8'h2A) begin
            errors++;
            $display("FAIL distinct_const got d=%0d s=%h m=%h exp d=7 s=5a m=2a", digit, maxScore, margin);
        end
    endtask

    task automatic test_tie();
        vec_t s;
        for (int i = 0; i < 10; i++) s[i] = 8'h10;
        s[3] = 8'h40; s[8] = 8'h40;
        run_and_check("tie", s, 1'b0);
        checks++;
        if (digit !== 4'd3 || margin !== 8'h00) begin
            errors++;
            $display("FAIL tie_const got d=%0d m=%h exp d=3 m=00", digit, margin);
        end
    endtask

    task automatic test_negzero();
        vec_t s;
        s = '0;
        s[5] = 8'h80;
        run_and_check("negzero", s, 1'b0);
        checks++;
        if (digit !== 4'd0 || maxScore !== 8'h00 || margin !== 8'h00) begin
            errors++;
            $display("FAIL negzero_const got d=%0d s=%h m=%h exp d=0 s=00 m=00", digit, maxScore, margin);
        end
    endtask

    task automatic test_last_index();
        vec_t s;
        for (int i = 0; i < 10; i++) s[i] = 8'hFF;
        s[9] = 8'h01;
        run_and_check("last_index", s, 1'b1);
        checks++;
        if (digit !== 4'd9 || maxScore !== 8'h01 || margin !== 8'h81 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL last_index_const got d=%0d s=%h m=%h o=%b exp d=9 s=01 m=81 o=1",
                     digit, maxScore, margin, overflow);
        end
    endtask

    task automatic test_back_to_back();
        vec_t a, b;
        int cyc = 0;
        logic [20:0] exp;
        for (int i = 0; i < 10; i++) begin
            a[i] = 8'($urandom_range(0, 255));
            b[i] = 8'($urandom_range(0, 127));
        end
        start_scan(a, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        iScores = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 4;
        wait_done(cyc);
        exp = exp_q.pop_front();
        checks++;
        if (cyc !== 10 || {digit, maxScore, margin, overflow} !== exp) begin
            errors++;
            $display("FAIL midscan_start_ignored got cyc=%0d res=%h exp cyc=10 res=%h",
                     cyc, {digit, maxScore, margin, overflow}, exp);
        end
        @(posedge clk); #1;
        start_scan(b, 1'b1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_restart got done=%b busy=%b exp done=0 busy=1", done, busy);
        end
        cyc = 0;
        wait_done(cyc);
        exp = exp_q.pop_front();
        checks++;
        if (cyc !== 10 || {digit, maxScore, margin, overflow} !== exp) begin
            errors++;
            $display("FAIL done_restart_result got cyc=%0d res=%h exp cyc=10 res=%h",
                     cyc, {digit, maxScore, margin, overflow}, exp);
        end
    endtask

    task automatic test_reset_midscan();
        vec_t s;
        for (int i = 0; i < 10; i++) s[i] = 8'(8'h11 * i);
        start_scan(s, 1'b1);
        repeat (4) @(posedge clk);
        #2;
        iRst = 1'b1;
        #1;
        checks++;
        if ({busy, done, digit, maxScore, margin, overflow} !== 23'd0) begin
            errors++;
            $display("FAIL async_reset got %h exp 0", {busy, done, digit, maxScore, margin, overflow});
        end
        exp_q.delete();
        @(posedge clk); #1;
        iRst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got done=%b busy=%b exp 0 0", done, busy);
        end
        run_and_check("post_reset", s, 1'b0);
    endtask

    task automatic test_ena_stall();
        vec_t s;
        int cyc = 0;
        logic [20:0] exp;
        for (int i = 0; i < 10; i++) s[i] = 8'($urandom_range(0, 255));
        s[6] = 8'h7E;
        start_scan(s, 1'b0);
        repeat (4) begin @(posedge clk); #1; cyc++; end
        ena = 1'b0;
        repeat (3) begin @(posedge clk); #1; cyc++; end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ena_hold got busy=%b done=%b exp 1 0", busy, done);
        end
        ena = 1'b1;
        wait_done(cyc);
        exp = exp_q.pop_front();
        checks++;
        if (cyc !== 13 || {digit, maxScore, margin, overflow} !== exp) begin
            errors++;
            $display("FAIL ena_stall got cyc=%0d res=%h exp cyc=13 res=%h",
                     cyc, {digit, maxScore, margin, overflow}, exp);
        end
    endtask

    task automatic test_random();
        vec_t s;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 10; i++) s[i] = 8'($urandom_range(0, 255));
            run_and_check("random", s, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_distinct();
        test_tie();
        test_negzero();
        test_last_index();
        test_back_to_back();
        test_reset_midscan();
        test_ena_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
